change_dispenser: RTL and testbench
===================================

# change_dispenser

Returns change after a vend. When the payment check reports the cost has been met or exceeded, the controller pulses `start` with the paid and cost amounts. This block then computes the change and drives the coin ejector one coin at a time over a valid/ack handshake, largest denomination first. It is the outgoing-money counterpart to the incoming payment comparison and sits between the vend controller and the coin ejector.

## Interface
Parameters:
- `WIDTH`, 4: width of money amounts, unsigned, in units.
- `D_HI`, 5: high coin denomination in units.
- `D_MID`, 2: middle coin denomination in units. The low coin is fixed at 1 unit.
- Legal values: `D_HI` > `D_MID` > 1, and `D_HI` < 2^`WIDTH`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle request; `paid` and `cost` are valid in the same cycle.
- `paid`  in  WIDTH  amount inserted.
- `cost`  in  WIDTH  price of the selected item.
- `busy`  out  1  high while coins are being issued.
- `coin_valid`  out  1  coin request to the ejector.
- `coin_sel`  out  2  denomination: 00 = `D_HI`, 01 = `D_MID`, 10 = 1 unit; 11 is never driven.
- `coin_ack`  in  1  ejector accepted the coin; sampled only while `coin_valid` is high.
- `done`  out  1  one-cycle pulse when all change is issued.
- `underpay`  out  1  one-cycle pulse when `paid` < `cost`.
- `change_total`  out  WIDTH  change amount latched at `start`.

## Operation
- States: IDLE, ISSUE, GAP, DONE. Register `rem` (WIDTH bits) holds the change still owed.
- IDLE, `start`=1:
  - `paid` < `cost` (unsigned compare, no wrap): pulse `underpay`; `change_total` ← 0; stay in IDLE; no `done`.
  - `paid` == `cost`: `change_total` ← 0; go to DONE.
  - `paid` > `cost`: `rem` and `change_total` ← `paid` − `cost`; go to ISSUE.
- ISSUE:
  - `coin_valid`=1.
  - `coin_sel` is the greedy choice from `rem`: if `rem` ≥ `D_HI` select HI; else if `rem` ≥ `D_MID` select MID; else select LO.
  - Hold `coin_valid` and `coin_sel` stable until `coin_ack`.
  - On `coin_ack`: `rem` ← `rem` − denomination. If the result is 0, go to DONE; otherwise go to GAP.
- GAP: `coin_valid`=0 for exactly one cycle, then return to ISSUE. This gives the mechanical ejector a spacing cycle.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `busy` is high in ISSUE and GAP only.
- `start` outside IDLE is ignored. `coin_ack` outside ISSUE is ignored.
- `change_total` holds its value until the next accepted `start`.
- `rst` forces IDLE from any state, including mid-issue. Reset clears `rem` to 0; owed change is discarded and no `done` is generated.

## Timing
- Reset values: `busy`=0, `coin_valid`=0, `coin_sel`=00, `done`=0, `underpay`=0, `change_total`=0.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Cycle numbering: `start` is sampled at edge E0; cycle 1 is the cycle after E0.
- `underpay` is high in cycle 1.
- An exact payment gives `done` high in cycle 1.
- Otherwise `coin_valid` first rises in cycle 1.
- With the ejector acking immediately, k coins give `done` in cycle 2k. Every cycle of ack delay adds one cycle.
- A new `start` is accepted no earlier than the cycle after `done` (IDLE).
- `rst` asserted with `coin_valid` high: `coin_valid` is low in the next cycle.

## Test plan
- Reset: assert `rst` for 2 cycles. Required: all outputs at their reset values, state IDLE.
- Basic change: `paid`=13, `cost`=4, immediate ack. Required:
  - `change_total`=9.
  - Coins issued in order HI, MID, MID (`coin_sel` 00, 01, 01), each separated by one GAP cycle with `coin_valid`=0.
  - `done` in cycle 6; `busy` high in cycles 1–5.
- Exact and underpay:
  - `paid`=7, `cost`=7: `done` in cycle 1, no `coin_valid`, `change_total`=0.
  - `paid`=3, `cost`=8: `underpay` in cycle 1, no `done`, `busy` stays 0.
- Stalled ejector: `paid`=15, `cost`=9, `coin_ack` held low for 4 cycles on the first coin. Required:
  - `coin_valid`/`coin_sel`=00 held stable for 5 cycles.
  - Coins issued: HI then LO; `done` in cycle 8.
- Ignored inputs: `start` pulsed with `paid`=15, `cost`=0 while ISSUE is in progress, and `coin_ack` pulsed during GAP. Required: no change in the coin sequence, `change_total`, or `rem`.
- Reset mid-operation: `paid`=15, `cost`=0; assert `rst` while the second coin is pending. Required: `coin_valid`=0 next cycle, no `done`, IDLE. A following `start` with `paid`=2, `cost`=1 issues one LO coin.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: computes paid - cost at start and issues the change one coin
// at a time, largest denomination first, over a valid/ack handshake to the ejector.
module change_dispenser #(
    parameter int WIDTH = 4,
    parameter int D_HI  = 5,
    parameter int D_MID = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] paid,
    input  logic [WIDTH-1:0] cost,
    output logic             busy,
    output logic             coin_valid,
    output logic [1:0]       coin_sel,
    input  logic             coin_ack,
    output logic             done,
    output logic             underpay,
    output logic [WIDTH-1:0] change_total,
    output logic [1:0]       dbg_state
);

    // Handshake: a coin transfers on a rising edge where coin_valid and coin_ack
    // are both high; coin_valid/coin_sel stay stable until then, and coin_ack is
    // ignored whenever coin_valid is low.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] L_HI  = WIDTH'(D_HI);
    localparam logic [WIDTH-1:0] L_MID = WIDTH'(D_MID);
    localparam logic [WIDTH-1:0] L_LO  = WIDTH'(1);

    localparam logic [1:0] SEL_HI  = 2'b00;
    localparam logic [1:0] SEL_MID = 2'b01;
    localparam logic [1:0] SEL_LO  = 2'b10;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic             r_busy;
    logic             r_coin_valid;
    logic [1:0]       r_coin_sel;
    logic             r_done;
    logic             r_underpay;
    logic [WIDTH-1:0] r_change_total;

    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_denom;
    logic [WIDTH-1:0] w_rem_next;

    function automatic logic [1:0] greedy_sel(input logic [WIDTH-1:0] amount);
        if (amount >= L_HI)
            return SEL_HI;
        else if (amount >= L_MID)
            return SEL_MID;
        else
            return SEL_LO;
    endfunction

    assign w_diff = paid - cost;

    always_comb begin
        w_denom = L_LO;
        case (r_coin_sel)
            SEL_HI:  w_denom = L_HI;
            SEL_MID: w_denom = L_MID;
            default: w_denom = L_LO;
        endcase
    end

    assign w_rem_next = r_rem - w_denom;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_rem          <= '0;
            r_busy         <= 1'b0;
            r_coin_valid   <= 1'b0;
            r_coin_sel     <= SEL_HI;
            r_done         <= 1'b0;
            r_underpay     <= 1'b0;
            r_change_total <= '0;
        end else begin
            r_done     <= 1'b0;
            r_underpay <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (paid < cost) begin
                            r_underpay     <= 1'b1;
                            r_change_total <= '0;
                        end else if (paid == cost) begin
                            r_change_total <= '0;
                            r_done         <= 1'b1;
                            r_state        <= DONE;
                        end else begin
                            r_rem          <= w_diff;
                            r_change_total <= w_diff;
                            r_coin_valid   <= 1'b1;
                            r_coin_sel     <= greedy_sel(w_diff);
                            r_busy         <= 1'b1;
                            r_state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (coin_ack) begin
                        r_rem        <= w_rem_next;
                        r_coin_valid <= 1'b0;
                        if (w_rem_next == '0) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= GAP;
                        end
                    end
                end
                GAP: begin
                    // Spacing cycle for the ejector; pick the next coin from what is left.
                    r_coin_valid <= 1'b1;
                    r_coin_sel   <= greedy_sel(r_rem);
                    r_state      <= ISSUE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign coin_valid   = r_coin_valid;
    assign coin_sel     = r_coin_sel;
    assign done         = r_done;
    assign underpay     = r_underpay;
    assign change_total = r_change_total;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: per-cycle logging of outputs during each
// vend, then scenario tasks compare the logs against hand-computed expectations.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] paid;
    logic [3:0] cost;
    logic       busy;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       coin_ack;
    logic       done;
    logic       underpay;
    logic [3:0] change_total;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic       v_log [0:39];
    logic       b_log [0:39];
    logic       d_log [0:39];
    logic       u_log [0:39];
    logic [1:0] s_log [0:39];
    logic [1:0] st_log[0:39];
    int         done_cyc;
    logic [1:0] coins[$];
    logic [1:0] exp_q[$];

    change_dispenser #(.WIDTH(4), .D_HI(5), .D_MID(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .paid         (paid),
        .cost         (cost),
        .busy         (busy),
        .coin_valid   (coin_valid),
        .coin_sel     (coin_sel),
        .coin_ack     (coin_ack),
        .done         (done),
        .underpay     (underpay),
        .change_total (change_total),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Drives one start, then logs ncyc cycles. stall: first-coin ack delay.
    // ign_cyc: cycle in which a stray start is driven (and ack pulsed in the next
    // cycle if it is a gap). rst_cyc: cycle in which reset is raised. -1 disables.
    task automatic run_txn(input logic [3:0] p, input logic [3:0] c, input int stall,
                           input int ncyc, input int ign_cyc, input int rst_cyc);
        int stall_left;
        stall_left = stall;
        coins.delete();
        done_cyc = -1;
        paid     = p;
        cost     = c;
        start    = 1'b1;
        coin_ack = 1'b0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk);
            #1;
            start    = 1'b0;
            coin_ack = 1'b0;
            rst      = 1'b0;
            v_log[cyc]  = coin_valid;
            b_log[cyc]  = busy;
            d_log[cyc]  = done;
            u_log[cyc]  = underpay;
            s_log[cyc]  = coin_sel;
            st_log[cyc] = dbg_state;
            if (done === 1'b1 && done_cyc < 0)
                done_cyc = cyc;
            if (cyc == rst_cyc)
                rst = 1'b1;
            if (coin_valid === 1'b1) begin
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    coin_ack = 1'b1;
                    if (cyc != rst_cyc)
                        coins.push_back(coin_sel);
                end
            end else if (cyc == ign_cyc + 1 && busy === 1'b1) begin
                coin_ack = 1'b1;
            end
            if (cyc == ign_cyc) begin
                start = 1'b1;
                paid  = 4'd15;
                cost  = 4'd0;
            end
        end
        coin_ack = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, coin_valid, coin_sel, done, underpay, change_total} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b sel=%b done=%b underpay=%b total=%0d, need all 0",
                     busy, coin_valid, coin_sel, done, underpay, change_total);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d need 0 (IDLE)", dbg_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_txn(4'd13, 4'd4, 0, 8, -1, -1);
        exp_q = '{2'b00, 2'b01, 2'b01};
        checks++;
        if (change_total !== 4'd9) begin
            errors++;
            $display("FAIL basic_total: got %0d need 9", change_total);
        end
        checks++;
        if (coins != exp_q) begin
            errors++;
            $display("FAIL basic_coins: got %p need %p", coins, exp_q);
        end
        checks++;
        if (done_cyc != 6) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d need 6", done_cyc);
        end
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (b_log[i] !== 1'b1 || v_log[i] !== ((i % 2) == 1)) begin
                errors++;
                $display("FAIL basic_busy_valid cycle %0d: got busy=%b valid=%b need busy=1 valid=%0d",
                         i, b_log[i], v_log[i], (i % 2));
            end
        end
        checks++;
        if (b_log[6] !== 1'b0 || d_log[7] !== 1'b0 || st_log[7] !== 2'd0) begin
            errors++;
            $display("FAIL basic_after_done: got busy6=%b done7=%b state7=%0d need 0,0,0",
                     b_log[6], d_log[7], st_log[7]);
        end
    endtask

    task automatic test_exact_and_underpay();
        run_txn(4'd7, 4'd7, 0, 4, -1, -1);
        checks++;
        if (done_cyc != 1 || d_log[2] !== 1'b0) begin
            errors++;
            $display("FAIL exact_done: got first cycle %0d, cycle2=%b need 1 and 0", done_cyc, d_log[2]);
        end
        checks++;
        if (v_log[1] !== 1'b0 || v_log[2] !== 1'b0 || change_total !== 4'd0) begin
            errors++;
            $display("FAIL exact_no_coin: got valid=%b%b total=%0d need 00 and 0",
                     v_log[1], v_log[2], change_total);
        end
        // Leave a nonzero total so the underpay clear is observable.
        run_txn(4'd3, 4'd1, 0, 4, -1, -1);
        run_txn(4'd3, 4'd8, 0, 4, -1, -1);
        checks++;
        if (u_log[1] !== 1'b1 || u_log[2] !== 1'b0) begin
            errors++;
            $display("FAIL underpay_pulse: got cycle1=%b cycle2=%b need 1 0", u_log[1], u_log[2]);
        end
        checks++;
        if (done_cyc != -1 || b_log[1] !== 1'b0 || v_log[1] !== 1'b0 || change_total !== 4'd0) begin
            errors++;
            $display("FAIL underpay_quiet: got done_cycle=%0d busy=%b valid=%b total=%0d need -1 0 0 0",
                     done_cyc, b_log[1], v_log[1], change_total);
        end
    endtask

    task automatic test_stall();
        run_txn(4'd15, 4'd9, 4, 10, -1, -1);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (v_log[i] !== 1'b1 || s_log[i] !== 2'b00) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got valid=%b sel=%b need 1 00", i, v_log[i], s_log[i]);
            end
        end
        exp_q = '{2'b00, 2'b10};
        checks++;
        if (coins != exp_q) begin
            errors++;
            $display("FAIL stall_coins: got %p need %p", coins, exp_q);
        end
        checks++;
        if (done_cyc != 8 || change_total !== 4'd6) begin
            errors++;
            $display("FAIL stall_done: got cycle %0d total %0d need 8 and 6", done_cyc, change_total);
        end
    endtask

    task automatic test_ignored_inputs();
        run_txn(4'd13, 4'd4, 0, 8, 1, -1);
        exp_q = '{2'b00, 2'b01, 2'b01};
        checks++;
        if (coins != exp_q) begin
            errors++;
            $display("FAIL ignored_coins: got %p need %p", coins, exp_q);
        end
        checks++;
        if (done_cyc != 6 || change_total !== 4'd9) begin
            errors++;
            $display("FAIL ignored_done_total: got cycle %0d total %0d need 6 and 9", done_cyc, change_total);
        end
        checks++;
        if (v_log[3] !== 1'b1 || s_log[3] !== 2'b01) begin
            errors++;
            $display("FAIL ignored_second_coin: got valid=%b sel=%b need 1 01", v_log[3], s_log[3]);
        end
    endtask

    task automatic test_reset_mid();
        run_txn(4'd15, 4'd0, 0, 8, -1, 3);
        checks++;
        if (v_log[3] !== 1'b1 || v_log[4] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid: got cycle3=%b cycle4=%b need 1 0", v_log[3], v_log[4]);
        end
        checks++;
        if (done_cyc != -1 || st_log[4] !== 2'd0 || b_log[4] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: got done_cycle=%0d state=%0d busy=%b need -1 0 0",
                     done_cyc, st_log[4], b_log[4]);
        end
        run_txn(4'd2, 4'd1, 0, 4, -1, -1);
        exp_q = '{2'b10};
        checks++;
        if (coins != exp_q || done_cyc != 2 || change_total !== 4'd1) begin
            errors++;
            $display("FAIL midrst_followup: got coins=%p done_cycle=%0d total=%0d need '{2} 2 1",
                     coins, done_cyc, change_total);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        coin_ack = 1'b0;
        paid     = '0;
        cost     = '0;
        test_reset();
        test_basic();
        test_exact_and_underpay();
        test_stall();
        test_ignored_inputs();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
